// File: rtl/text_fill_engine.sv
// Text RAM fill engine: walks every character cell of a COLS x ROWS screen,
// writing either a constant fill or a row-shaded running-character pattern.
module text_fill_engine #(
    parameter int COLS    = 120,
    parameter int ROWS    = 61,
    parameter int ADDR_W  = 13,
    parameter int COLOR_W = 4,
    parameter int BLINK_W = 2,
    localparam int DATA_W = BLINK_W + 2*COLOR_W + 8
) (
    input  logic               clk50,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic [1:0]         Mode,
    input  logic [7:0]         FillChar,
    input  logic [COLOR_W-1:0] FillFG,
    input  logic [COLOR_W-1:0] FillBG,
    input  logic [BLINK_W-1:0] FillBlink,
    input  logic [7:0]         SeedChar,
    output logic               Busy,
    output logic               Done,
    output logic [ADDR_W-1:0]  WAddr,
    output logic [DATA_W-1:0]  WData,
    output logic               Write,
    output logic [15:0]        Frame
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    if (COLS*ROWS > 2**ADDR_W) begin : g_addr_too_small
        $error("text_fill_engine: COLS*ROWS does not fit in ADDR_W address bits");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DATA, S_WRITE, S_ADVANCE} state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [7:0]          r_fchar, r_seed, r_char;
    logic [COLOR_W-1:0]  r_fg, r_bg;
    logic [BLINK_W-1:0]  r_blink;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic                r_stop, r_busy, r_done, r_write;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [15:0]         r_frame;

    logic                w_cont, w_pat, w_col_wrap, w_last;
    logic [COL_W-1:0]    w_ncol;
    logic [ROW_W-1:0]    w_nrow;
    logic [7:0]          w_nchar, w_seed;

    // Pattern modes shade each row: FG counts down and BG counts up from FillBG.
    function automatic logic [DATA_W-1:0] f_cell(input logic pat, input logic [7:0] ch,
                                                 input logic [ROW_W-1:0] row);
        logic [ROW_W+COLOR_W-1:0] rx;
        logic [COLOR_W-1:0]       rlo, fg, bg;
        rx  = {{COLOR_W{1'b0}}, row};
        rlo = rx[COLOR_W-1:0];
        fg  = pat ? ({COLOR_W{1'b1}} - rlo) : r_fg;
        bg  = pat ? (rlo + r_bg) : r_bg;
        return {r_blink, bg, fg, ch};
    endfunction

    assign w_cont     = (r_mode == 2'd2);
    assign w_pat      = (r_mode == 2'd1) || w_cont;
    assign w_col_wrap = (r_col == COL_W'(COLS-1));
    assign w_last     = w_col_wrap && (r_row == ROW_W'(ROWS-1));
    assign w_ncol     = w_col_wrap ? '0 : r_col + COL_W'(1);
    assign w_nrow     = w_col_wrap ? r_row + ROW_W'(1) : r_row;
    assign w_nchar    = w_pat ? r_char + 8'd1 : r_char;
    assign w_seed     = w_cont ? r_frame[15:8] : (w_pat ? r_seed : r_fchar);

    always_ff @(posedge clk50) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_fchar <= '0;
            r_seed  <= '0;
            r_char  <= '0;
            r_fg    <= '0;
            r_bg    <= '0;
            r_blink <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_write <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_frame <= '0;
        end else begin
            if (r_state != S_IDLE && w_cont && Stop)
                r_stop <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_stop <= 1'b0;
                    if (Start) begin
                        r_mode  <= Mode;
                        r_fchar <= FillChar;
                        r_fg    <= FillFG;
                        r_bg    <= FillBG;
                        r_blink <= FillBlink;
                        r_seed  <= SeedChar;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_waddr <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_char  <= w_seed;
                    r_wdata <= f_cell(w_pat, w_seed, '0);
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    r_write <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_write <= 1'b0;
                    // Decide here so Done is visible during the final ADVANCE cycle.
                    if (w_last)
                        r_done <= !w_cont || r_stop || Stop;
                    r_state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    r_done  <= 1'b0;
                    r_col   <= w_ncol;
                    r_row   <= w_nrow;
                    r_char  <= w_nchar;
                    r_waddr <= r_waddr + ADDR_W'(1);
                    if (!w_last) begin
                        r_wdata <= f_cell(w_pat, w_nchar, w_nrow);
                        r_state <= S_DATA;
                    end else begin
                        r_frame <= r_frame + 16'd1;
                        if (r_done) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_waddr <= '0;
                            r_state <= S_SETUP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign WAddr = r_waddr;
    assign WData = r_wdata;
    assign Write = r_write;
    assign Frame = r_frame;
endmodule

// File: doc/text_fill_engine.md
TEXT_FILL_ENGINE -- requirements
Module: text_fill_engine

Interface
REQ-001 Parameter COLS, default 120: character cells per row.
REQ-002 Parameter ROWS, default 61: rows per screen.
REQ-003 Parameter ADDR_W, default 13: text RAM address width; elaboration SHALL fail if COLS*ROWS > 2**ADDR_W.
REQ-004 Parameter COLOR_W, default 4, and BLINK_W, default 2: colour and blink field widths; character field fixed at 8 bits; DATA_W = BLINK_W+2*COLOR_W+8 (18 at defaults).
REQ-005 Port clk50, input, 1: single clock; all logic on its rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port Start, input, 1: pass request, sampled only in IDLE.
REQ-008 Port Stop, input, 1: ends continuous mode at next pass boundary.
REQ-009 Port Mode, input, 2: 0 CLEAR, 1 PATTERN, 2 CONTINUOUS, 3 treated as CLEAR.
REQ-010 Ports FillChar (8), FillFG (COLOR_W), FillBG (COLOR_W), FillBlink (BLINK_W), SeedChar (8), inputs: pass operands.
REQ-011 Port Busy, output, 1: high from the cycle after Start is accepted until Done.
REQ-012 Port Done, output, 1: one-cycle pulse when the engine returns to IDLE.
REQ-013 Ports WAddr (ADDR_W), WData (DATA_W), Write (1), outputs: text RAM write port; WData = {Blink, BG, FG, Char}.
REQ-014 Port Frame, output, 16: completed-pass counter.

Function
REQ-015 States: IDLE, SETUP, DATA, WRITE, ADVANCE; three cycles per cell (DATA, WRITE, ADVANCE).
REQ-016 IDLE: Start=1 captures Mode and all operand inputs into internal registers, clears row/col/WAddr to 0, goes to SETUP; Start=0 stays in IDLE.
REQ-017 SETUP: loads the pass's character seed (CLEAR: FillChar; PATTERN: SeedChar; CONTINUOUS: Frame[15:8]) and goes to DATA.
REQ-018 DATA: drives WData for the current cell; WAddr already valid; Write=0.
REQ-019 WRITE: Write=1 for exactly one cycle; WAddr and WData are stable through DATA, WRITE and ADVANCE.
REQ-020 ADVANCE: Write=0; if col<COLS-1, col+1; else col=0, row+1; WAddr+1 in both cases; char+1 mod 256 in PATTERN/CONTINUOUS; next state DATA unless the cell just written was the last (row=ROWS-1, col=COLS-1).
REQ-021 CLEAR cell: Char=FillChar, FG=FillFG, BG=FillBG, Blink=FillBlink for every cell.
REQ-022 PATTERN/CONTINUOUS cell: Char=running char (first cell = seed); FG = all-ones minus row[COLOR_W-1:0]; BG = row[COLOR_W-1:0] + FillBG mod 2**COLOR_W; Blink=FillBlink.
REQ-023 End of pass (ADVANCE on last cell): Frame+1 mod 2**16; in CLEAR or PATTERN, or in CONTINUOUS with Stop seen, go to IDLE with Done=1 for that one transition cycle; otherwise go to SETUP with row/col/WAddr cleared and a new seed.
REQ-024 Stop is latched whenever asserted during a CONTINUOUS pass and cleared on entering IDLE; Stop in CLEAR/PATTERN or in IDLE has no effect.
REQ-025 Start while not in IDLE is ignored; operand changes mid-pass have no effect.
REQ-026 Start and Done in the same cycle: Done completes, Start is ignored; a new pass starts only on a Start seen in IDLE.
REQ-027 Total writes per pass is exactly COLS*ROWS; WAddr never exceeds COLS*ROWS-1 during a write.

Reset
REQ-028 Reset=1 at a clock edge forces IDLE, Write=0, Busy=0, Done=0, WAddr=0, WData=0, Frame=0, row/col=0, Stop latch clear; the same applies mid-pass, with no further writes.
REQ-029 The first Start is accepted on the first edge with Reset=0.

Verification (COLS=4, ROWS=3 unless noted)
REQ-030 CLEAR: Mode=0, FillChar=8'h20, FG=4'h7, BG=4'h1, Blink=0, Start pulse -> 12 writes, addresses 0..11, each WData=18'h01720; Done once, 36 cycles after SETUP; Frame=1.
REQ-031 PATTERN: Mode=1, SeedChar=8'hFE, FillBG=4'h2 -> chars FE,FF,00,01,...; row 2 cells FG=4'hD, BG=4'h4; Write high exactly 12 cycles.
REQ-032 CONTINUOUS: Mode=2, run 3 passes, then Stop during pass 3 -> pass 2 seed=Frame[15:8] of that time; Done after pass 3 only; Frame=3; Busy continuous throughout.
REQ-033 Reset mid-pass: Reset asserted on the WRITE cycle of cell 5 -> next cycle Write=0, Busy=0, Frame=0; Start then rewrites from address 0.
REQ-034 Start held high through the whole pass and Start pulses while Busy -> exactly one pass and a single Done; a new pass follows only after the IDLE cycle.
REQ-035 Defaults (120x61): full CLEAR pass -> 7320 writes, last WAddr=13'h1C97, Frame wraps from 16'hFFFF to 0 on preload test.
